// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: function_3 ops, FSM states,
// and helpers that decide which operands are treated as signed.
package muldiv_unit_pkg;

    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

    typedef enum logic [2:0] {
        MULDIV_MUL    = 3'b000,
        MULDIV_MULH   = 3'b001,
        MULDIV_MULHSU = 3'b010,
        MULDIV_MULHU  = 3'b011,
        MULDIV_DIV    = 3'b100,
        MULDIV_DIVU   = 3'b101,
        MULDIV_REM    = 3'b110,
        MULDIV_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10,
        MD_DONE = 2'b11
    } md_state_e;

    function automatic logic op_is_div(input logic [2:0] f);
        return f[2];
    endfunction

    function automatic logic a_is_signed(input logic [2:0] f);
        return (f == MULDIV_MUL) || (f == MULDIV_MULH) || (f == MULDIV_MULHSU) ||
               (f == MULDIV_DIV) || (f == MULDIV_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f);
        return (f == MULDIV_MUL) || (f == MULDIV_MULH) ||
               (f == MULDIV_DIV) || (f == MULDIV_REM);
    endfunction

endpackage

// File: rtl/muldiv_sign_correct.sv
// Final-cycle result selection: restores signs on the magnitude results and
// applies the divide-by-zero results.
module muldiv_sign_correct
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        function_3,
    input  logic              sign_q,
    input  logic              sign_a,
    input  logic              div0,
    input  logic [2*XLEN-1:0] product,
    input  logic [XLEN-1:0]   quotient,
    input  logic [XLEN-1:0]   remainder,
    input  logic [XLEN-1:0]   operand_a,
    output logic [XLEN-1:0]   result_next
);

    logic [2*XLEN-1:0] product_fix;
    logic [XLEN-1:0]   quotient_fix;
    logic [XLEN-1:0]   remainder_fix;

    always_comb begin
        product_fix   = sign_q ? -product : product;
        quotient_fix  = sign_q ? -quotient : quotient;
        remainder_fix = sign_a ? -remainder : remainder;
        result_next   = '0;
        case (function_3)
            MULDIV_MUL:                               result_next = product_fix[XLEN-1:0];
            MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU: result_next = product_fix[2*XLEN-1:XLEN];
            // A zero divisor bypasses sign correction entirely
            MULDIV_DIV, MULDIV_DIVU:                  result_next = div0 ? '1 : quotient_fix;
            default:                                  result_next = div0 ? operand_a : remainder_fix;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle on operand magnitudes,
// sign fix in a final cycle, fixed XLEN+2 cycle latency from start to result_valid.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      function_3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;

    md_state_e         state_reg;
    logic [2:0]        op_reg;
    logic [XLEN-1:0]   opnd_reg;     // multiplicand for MUL*, divisor for DIV*/REM*
    logic [XLEN-1:0]   a_raw_reg;
    logic [2*XLEN-1:0] acc_reg;      // {hi, lo}: product, or {remainder, quotient}
    logic [CW-1:0]     counter_reg;
    logic              sign_q_reg;
    logic              sign_a_reg;
    logic              div0_reg;
    logic              busy_reg;
    logic              valid_reg;
    logic [XLEN-1:0]   result_reg;

    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0]   result_next;

    always_comb begin
        a_neg = a_is_signed(function_3) && operand_a[XLEN-1];
        b_neg = b_is_signed(function_3) && operand_b[XLEN-1];
        a_mag = a_neg ? -operand_a : operand_a;
        b_mag = b_neg ? -operand_b : operand_b;
    end

    // Shift-add: add multiplicand into the high half when the multiplier LSB is set
    always_comb begin
        mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
        mul_next = {mul_sum, acc_reg[XLEN-1:1]};
    end

    // Restoring division: trial-subtract the divisor from the shifted partial remainder
    always_comb begin
        div_shift = acc_reg[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opnd_reg};
        if (div_diff[XLEN])
            div_next = {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
        else
            div_next = {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
    end

    muldiv_sign_correct #(.XLEN(XLEN)) u_sign_correct (
        .function_3  (op_reg),
        .sign_q      (sign_q_reg),
        .sign_a      (sign_a_reg),
        .div0        (div0_reg),
        .product     (acc_reg),
        .quotient    (acc_reg[XLEN-1:0]),
        .remainder   (acc_reg[2*XLEN-1:XLEN]),
        .operand_a   (a_raw_reg),
        .result_next (result_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= MD_IDLE;
            op_reg      <= '0;
            opnd_reg    <= '0;
            a_raw_reg   <= '0;
            acc_reg     <= '0;
            counter_reg <= '0;
            sign_q_reg  <= 1'b0;
            sign_a_reg  <= 1'b0;
            div0_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            result_reg  <= '0;
        end else if (flush) begin
            state_reg <= MD_IDLE;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                MD_IDLE, MD_DONE: begin
                    valid_reg <= 1'b0;
                    if (start) begin
                        op_reg      <= function_3;
                        a_raw_reg   <= operand_a;
                        sign_q_reg  <= a_neg ^ b_neg;
                        sign_a_reg  <= a_neg;
                        div0_reg    <= (operand_b == '0);
                        counter_reg <= '0;
                        if (op_is_div(function_3)) begin
                            opnd_reg <= b_mag;
                            acc_reg  <= {{XLEN{1'b0}}, a_mag};
                        end else begin
                            opnd_reg <= a_mag;
                            acc_reg  <= {{XLEN{1'b0}}, b_mag};
                        end
                        busy_reg  <= 1'b1;
                        state_reg <= MD_CALC;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= MD_IDLE;
                    end
                end
                MD_CALC: begin
                    acc_reg     <= op_is_div(op_reg) ? div_next : mul_next;
                    counter_reg <= counter_reg + 1'b1;
                    if (counter_reg == CW'(XLEN - 1))
                        state_reg <= MD_FIX;
                end
                default: begin
                    result_reg <= result_next;
                    valid_reg  <= 1'b1;
                    busy_reg   <= 1'b0;
                    state_reg  <= MD_DONE;
                end
            endcase
        end
    end

    assign busy         = busy_reg;
    assign result_valid = valid_reg;
    assign result       = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed ops push expected results and due cycles,
// a monitor pops and compares on every result_valid.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        flush;
    logic [2:0]  function_3;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;

    muldiv_unit #(.XLEN(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .function_3   (function_3),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .flush        (flush),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] val;
        int          due;
        string       name;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expv;
        string       name;
    } vec_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          passes = 0;
    logic [31:0] last_exp = '0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    endfunction

    // Monitor: every result_valid must match the oldest outstanding expectation
    always @(negedge clock) begin
        exp_t e;
        if (!reset && result_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL spurious_valid: result_valid with result 0x%08h at cycle %0d, required no valid", result, cyc);
            end else begin
                e = exp_q.pop_front();
                check(e.name, result, e.val);
                check({e.name, "_latency"}, 32'(cyc), 32'(e.due));
                $display("txn %s result=0x%08h cycle=%0d", e.name, result, cyc);
            end
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv, input string name, input bit push);
        @(posedge clock); #1;
        function_3 = f;
        operand_a  = a;
        operand_b  = b;
        start      = 1'b1;
        if (push) begin
            exp_q.push_back('{expv, cyc + 34, name});
            last_exp = expv;
        end
        @(posedge clock); #1;
        start      = 1'b0;
        function_3 = 3'($urandom);
        operand_a  = $urandom;
        operand_b  = $urandom;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 80) begin
            @(posedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    vec_t vecs[13] = '{
        '{MULDIV_MULH,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "mulh"},
        '{MULDIV_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "mulhsu"},
        '{MULDIV_MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, "mulhu"},
        '{MULDIV_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_m7_2"},
        '{MULDIV_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_m7_2"},
        '{MULDIV_DIVU,   32'd100,       32'd7,         32'd14,        "divu_100_7"},
        '{MULDIV_REMU,   32'd100,       32'd7,         32'd2,         "remu_100_7"},
        '{MULDIV_DIV,    32'h0000_1234, 32'd0,         32'hFFFF_FFFF, "div_by0"},
        '{MULDIV_DIVU,   32'h0000_1234, 32'd0,         32'hFFFF_FFFF, "divu_by0"},
        '{MULDIV_REM,    32'h0000_1234, 32'd0,         32'h0000_1234, "rem_by0"},
        '{MULDIV_REMU,   32'h0000_1234, 32'd0,         32'h0000_1234, "remu_by0"},
        '{MULDIV_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf"},
        '{MULDIV_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf"}
    };

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        int n;
        reset      = 1'b1;
        start      = 1'b0;
        flush      = 1'b0;
        function_3 = '0;
        operand_a  = '0;
        operand_b  = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_valid", {31'b0, result_valid}, 32'd0);
        check("reset_result", result, 32'd0);

        // MUL 7 x -3 with busy window check
        issue(MULDIV_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3", 1);
        bc = 0;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clock);
            if (busy) bc++;
        end
        check("mul_busy_cycles", 32'(bc), 32'd33);
        @(negedge clock);
        check("mul_busy_in_done", {31'b0, busy}, 32'd0);
        wait_drain();

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expv, vecs[i].name, 1);
            wait_drain();
        end

        // Flush at cycle 10 of a DIV, with a coincident start that must be dropped
        issue(MULDIV_DIVU, 32'd100, 32'd7, 32'd14, "divu_pre_flush", 1);
        wait_drain();
        issue(MULDIV_DIV, 32'd1000, 32'd3, 32'd0, "div_flushed", 0);
        repeat (9) @(posedge clock);
        #1;
        flush = 1'b1; start = 1'b1; function_3 = MULDIV_DIVU; operand_a = 32'd50; operand_b = 32'd5;
        @(posedge clock); #1;
        flush = 1'b0; start = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        repeat (40) @(posedge clock);
        #1;
        check("flush_result_hold", result, last_exp);
        check("flush_busy_after", {31'b0, busy}, 32'd0);

        // Flush and start together while idle
        flush = 1'b1; start = 1'b1; function_3 = MULDIV_MUL; operand_a = 32'd5; operand_b = 32'd5;
        @(posedge clock); #1;
        flush = 1'b0; start = 1'b0;
        check("idle_flush_start_busy", {31'b0, busy}, 32'd0);
        repeat (40) @(posedge clock);
        #1;
        check("idle_flush_result_hold", result, last_exp);

        // Reset at cycle 10 of a DIV
        issue(MULDIV_DIV, 32'd1000, 32'd3, 32'd0, "div_reset", 0);
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b1; start = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0; start = 1'b0;
        check("midop_reset_busy", {31'b0, busy}, 32'd0);
        check("midop_reset_result", result, 32'd0);
        repeat (40) @(posedge clock);
        #1;
        check("midop_reset_valid", {31'b0, result_valid}, 32'd0);

        // Back-to-back ops with ignored starts while busy
        issue(MULDIV_DIVU, 32'd1000, 32'd10, 32'd100, "b2b_op1", 1);
        repeat (3) @(posedge clock);
        #1;
        start = 1'b1; function_3 = MULDIV_MUL; operand_a = 32'd3; operand_b = 32'd3;
        @(posedge clock); #1;
        start = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!result_valid && n < 50);
        if (!result_valid) begin
            checks++;
            $display("FAIL b2b_op1_timeout: no result_valid within %0d cycles, required one", n);
        end else begin
            start = 1'b1; function_3 = MULDIV_REMU; operand_a = 32'd1000; operand_b = 32'd7;
            exp_q.push_back('{32'd6, cyc + 34, "b2b_op2"});
            @(posedge clock); #1;
            start = 1'b0;
            for (int k = 0; k < 3; k++) begin
                repeat (4) @(posedge clock);
                #1;
                start = 1'b1; function_3 = MULDIV_MULHU; operand_a = $urandom; operand_b = $urandom;
                @(posedge clock); #1;
                start = 1'b0;
            end
        end
        wait_drain();
        repeat (40) @(posedge clock);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
